eeprom_initiator: RTL and testbench



---
 rtl/eeprom_initiator.sv | 229 ++++++++++++++++++++++
 tb/tb_eeprom_initiator.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eeprom_initiator.sv
// Initiator for the 24C64-class serial EEPROM: single-byte random write/read.
// Each bit slot is four quarters; line levels are registered per position.
module eeprom_initiator #(
  parameter int unsigned QUARTER  = 2,
  parameter logic [6:0]  DEV_ADDR = 7'h50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_ce,
  input  logic        start,
  input  logic        rw,
  input  logic [12:0] mem_address,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        done,
  output logic        ack_error,
  output logic        scl,
  output logic        sda_out,
  input  logic        sda_in
);

  typedef enum logic [3:0] {
    IDLE, START, SEND_BYTE, GET_ACK, RESTART,
    RECV_BYTE, SEND_NACK, STOP, DONE
  } state_t;

  localparam logic [7:0] QLAST = 8'(QUARTER - 1);

  state_t      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [7:0]  quarter_q, quarter_d;
  logic [2:0]  bit_q, bit_d;
  logic [2:0]  idx_q, idx_d;
  logic        rw_q, rw_d;
  logic [12:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ack_error_q, ack_error_d;
  logic        scl_q, scl_d;
  logic        sda_q, sda_d;

  logic        q_last;
  logic        slot_end;
  logic        samp_tick;
  logic [7:0]  tx_byte;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    quarter_d   = quarter_q;
    bit_d       = bit_q;
    idx_d       = idx_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rx_d        = rx_q;
    rdata_d     = rdata_q;
    busy_d      = busy_q;
    done_d      = done_q;
    ack_error_d = ack_error_q;
    scl_d       = scl_q;
    sda_d       = sda_q;
    q_last      = (quarter_q == QLAST);
    slot_end    = q_last && (phase_q == 2'd3);
    samp_tick   = q_last && (phase_q == 2'd2);
    tx_byte     = 8'h00;

    if (clk_ce) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            rw_d        = rw;
            addr_d      = mem_address;
            wdata_d     = wdata;
            busy_d      = 1'b1;
            ack_error_d = 1'b0;
            phase_d     = 2'd0;
            quarter_d   = 8'd0;
            bit_d       = 3'd0;
            idx_d       = 3'd0;
            state_d     = START;
          end
        end
        DONE: begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
        default: begin
          if (q_last) begin
            quarter_d = 8'd0;
            phase_d   = phase_q + 2'd1;
          end else begin
            quarter_d = quarter_q + 8'd1;
          end
          if (samp_tick && state_q == GET_ACK && sda_in)
            ack_error_d = 1'b1;
          if (samp_tick && state_q == RECV_BYTE)
            rx_d = {rx_q[6:0], sda_in};
          if (slot_end) begin
            unique case (state_q)
              START, RESTART: state_d = SEND_BYTE;
              SEND_BYTE: begin
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = GET_ACK;
              end
              GET_ACK: begin
                if (ack_error_q) begin
                  state_d = STOP;
                end else begin
                  unique case (idx_q)
                    3'd2: begin
                      if (rw_q) begin
                        state_d = RESTART;
                        idx_d   = 3'd4;
                      end else begin
                        state_d = SEND_BYTE;
                        idx_d   = 3'd3;
                      end
                    end
                    3'd3: state_d = STOP;
                    3'd4: state_d = RECV_BYTE;
                    default: begin
                      state_d = SEND_BYTE;
                      idx_d   = idx_q + 3'd1;
                    end
                  endcase
                end
              end
              RECV_BYTE: begin
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = SEND_NACK;
              end
              SEND_NACK: begin
                rdata_d = rx_q;
                state_d = STOP;
              end
              STOP: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = DONE;
              end
              default: state_d = state_q;
            endcase
          end
        end
      endcase

      unique case (idx_d)
        3'd0:    tx_byte = {DEV_ADDR, 1'b0};
        3'd1:    tx_byte = {3'b000, addr_d[12:8]};
        3'd2:    tx_byte = addr_d[7:0];
        3'd3:    tx_byte = wdata_d;
        default: tx_byte = {DEV_ADDR, 1'b1};
      endcase

      // Line levels follow the position being entered on this tick.
      unique case (state_d)
        START, RESTART: begin
          scl_d = ~phase_d[1];
          sda_d = (phase_d == 2'd0);
        end
        SEND_BYTE: begin
          scl_d = phase_d[1] ^ phase_d[0];
          sda_d = tx_byte[~bit_d];
        end
        GET_ACK, RECV_BYTE, SEND_NACK: begin
          scl_d = phase_d[1] ^ phase_d[0];
          sda_d = 1'b1;
        end
        STOP: begin
          scl_d = (phase_d != 2'd0);
          sda_d = phase_d[1];
        end
        default: begin
          scl_d = 1'b1;
          sda_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_q     <= 2'd0;
      quarter_q   <= 8'd0;
      bit_q       <= 3'd0;
      idx_q       <= 3'd0;
      rw_q        <= 1'b0;
      addr_q      <= 13'd0;
      wdata_q     <= 8'd0;
      rx_q        <= 8'd0;
      rdata_q     <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_error_q <= 1'b0;
      scl_q       <= 1'b1;
      sda_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      quarter_q   <= quarter_d;
      bit_q       <= bit_d;
      idx_q       <= idx_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rx_q        <= rx_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ack_error_q <= ack_error_d;
      scl_q       <= scl_d;
      sda_q       <= sda_d;
    end
  end

  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ack_error = ack_error_q;
  assign scl       = scl_q;
  assign sda_out   = sda_q;

endmodule

// File: tb/tb_eeprom_initiator.sv
// Bench for eeprom_initiator with a behavioural 24C64 slave on the lines.
// Transaction table plus directed sequences for glitch, reset and re-start.
module tb_eeprom_initiator;

  logic        clk, reset, clk_ce, start, rw;
  logic [12:0] mem_address;
  logic [7:0]  wdata, rdata;
  logic        busy, done, ack_error, scl, sda_out, sda_in;

  bit nodev, ce_half;
  int checks, failures;

  eeprom_initiator #(.QUARTER(1), .DEV_ADDR(7'h50)) dut (
    .clk(clk), .reset(reset), .clk_ce(clk_ce), .start(start), .rw(rw),
    .mem_address(mem_address), .wdata(wdata), .rdata(rdata), .busy(busy),
    .done(done), .ack_error(ack_error), .scl(scl), .sda_out(sda_out),
    .sda_in(sda_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    clk_ce = 1'b1;
    forever begin
      @(negedge clk);
      clk_ce = ce_half ? ~clk_ce : 1'b1;
    end
  end

  // Slave model, updated on the falling system clock edge
  bit [7:0]    mem [8192];
  bit          pscl = 1'b1, psda = 1'b1;
  bit          m_drive = 1'b1, m_rd, m_rdp;
  int          m_bit, m_byte, starts, stops;
  logic [7:0]  m_sh, dev_byte;
  logic [12:0] m_ptr;

  assign sda_in = nodev ? 1'b1 : m_drive;

  initial begin
    m_sh = 8'h00; dev_byte = 8'h00; m_ptr = 13'd0;
    forever begin
      @(negedge clk);
      if (scl && pscl && psda && !sda_out) begin
        starts++; m_bit = 0; m_byte = 0; m_rd = 0; m_rdp = 0; m_drive = 1;
      end else if (scl && pscl && !psda && sda_out) begin
        stops++; m_rd = 0; m_bit = 0; m_drive = 1;
      end else if (scl && !pscl) begin
        if (!m_rd && m_bit < 8) begin
          m_sh = {m_sh[6:0], sda_out}; m_bit++;
        end
      end else if (!scl && pscl) begin
        if (m_rd) begin
          m_bit++;
          if (m_bit < 8) m_drive = m_sh[7 - m_bit];
          else if (m_bit == 8) m_drive = 1;
          else begin m_rd = 0; m_bit = 0; m_ptr++; end
        end else if (m_bit == 8) begin
          if (m_byte == 0) begin
            dev_byte = m_sh;
            if (m_sh[7:1] == 7'h50) begin m_drive = 0; m_rdp = m_sh[0]; end
          end else begin
            m_drive = 0;
            if (m_byte == 1) m_ptr[12:8] = m_sh[4:0];
            else if (m_byte == 2) m_ptr[7:0] = m_sh;
            else begin mem[m_ptr] = m_sh; m_ptr++; end
          end
          m_byte++; m_bit = 9;
        end else if (m_bit == 9) begin
          m_drive = 1; m_bit = 0;
          if (m_rdp) begin
            m_rd = 1; m_rdp = 0; m_sh = mem[m_ptr]; m_drive = m_sh[7];
          end
        end
      end
      pscl = scl; psda = sda_out;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Expected {scl,sda} for quarter k of a write transaction
  function automatic logic [1:0] exp_wr(input int k, input logic [12:0] a,
                                        input logic [7:0] d);
    int slot, q, s, b;
    logic [7:0] bv;
    logic cl, da;
    slot = k / 4; q = k % 4;
    if (slot == 0) begin
      cl = (q < 2); da = (q == 0);
    end else if (slot == 37) begin
      cl = (q != 0); da = (q >= 2);
    end else begin
      s = slot - 1; b = s % 9;
      case (s / 9)
        0: bv = 8'hA0;
        1: bv = {3'b000, a[12:8]};
        2: bv = a[7:0];
        default: bv = d;
      endcase
      cl = (q == 1) || (q == 2);
      da = (b == 8) ? 1'b1 : bv[7 - b];
    end
    return {cl, da};
  endfunction

  task automatic accept();
    do @(posedge clk); while (!clk_ce);
    #1;
  endtask

  task automatic wait_done(input bit wave, input logic [12:0] a,
                           input logic [7:0] d, input int glitch_at,
                           output int ticks);
    int n, wbad, fbad;
    logic [12:0] snap;
    n = 0; wbad = 0; fbad = 0; ticks = -1;
    snap = {scl, sda_out, busy, done, ack_error, rdata};
    for (int c = 0; c < 3000 && ticks < 0; c++) begin
      @(posedge clk);
      if (clk_ce) begin
        n++;
        #1;
        if (done) ticks = n;
        else if (wave && {scl, sda_out} !== exp_wr(n, a, d)) wbad++;
        if (n == glitch_at) begin
          start = 1; rw = ~rw; mem_address = ~mem_address; wdata = ~wdata;
        end
        if (n == glitch_at + 1) start = 0;
        snap = {scl, sda_out, busy, done, ack_error, rdata};
      end else begin
        #1;
        if ({scl, sda_out, busy, done, ack_error, rdata} !== snap) fbad++;
      end
    end
    chk("busy_at_done", busy, 0);
    if (wave) chk("waveform_errors", wbad, 0);
    if (ce_half) chk("frozen_errors", fbad, 0);
  endtask

  task automatic run_txn(input bit r, input logic [12:0] a,
                         input logic [7:0] d, input int glitch_at,
                         output int ticks, output int nstart,
                         output int nstop);
    int s0, p0;
    bit wave;
    wave = !r && !nodev;
    s0 = starts; p0 = stops;
    rw = r; mem_address = a; wdata = d; start = 1;
    accept();
    start = 0;
    if (wave) chk("waveform_k0", {scl, sda_out}, exp_wr(0, a, d));
    wait_done(wave, a, d, glitch_at, ticks);
    accept();
    chk("done_pulse", done, 0);
    nstart = starts - s0;
    nstop = stops - p0;
  endtask

  typedef struct {
    bit          rw;
    logic [12:0] addr;
    logic [7:0]  wd;
    bit          nodev;
    bit          half;
    int          lat;
    bit          err;
    logic [7:0]  rd;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int t, ns, np;
    tbl[0] = '{0, 13'h1234, 8'h5A, 0, 0, 152, 0, 8'h00};
    tbl[1] = '{1, 13'h1234, 8'h00, 0, 0, 192, 0, 8'h5A};
    tbl[2] = '{0, 13'h0100, 8'h33, 1, 0,  44, 1, 8'h5A};
    tbl[3] = '{0, 13'h1FFF, 8'hC3, 0, 0, 152, 0, 8'h5A};
    tbl[4] = '{1, 13'h1FFF, 8'h00, 0, 0, 192, 0, 8'hC3};
    tbl[5] = '{0, 13'h0000, 8'h81, 0, 1, 152, 0, 8'hC3};
    tbl[6] = '{1, 13'h0000, 8'h00, 0, 1, 192, 0, 8'h81};
    tbl[7] = '{1, 13'h1234, 8'h00, 1, 0,  44, 1, 8'h81};
    tbl[8] = '{1, 13'h1234, 8'h00, 0, 0, 192, 0, 8'h5A};

    reset = 1; start = 0; rw = 0; mem_address = 0; wdata = 0;
    nodev = 0; ce_half = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_lines", {scl, sda_out, busy, done, ack_error}, 5'b11000);
    chk("reset_rdata", rdata, 8'h00);
    @(negedge clk) reset = 0;
    @(posedge clk);
    #1;
    chk("idle_lines", {scl, sda_out, busy, done, ack_error}, 5'b11000);

    for (int i = 0; i < 9; i++) begin
      nodev = tbl[i].nodev;
      ce_half = tbl[i].half;
      repeat (4) @(posedge clk);
      #1;
      run_txn(tbl[i].rw, tbl[i].addr, tbl[i].wd, -1, t, ns, np);
      chk($sformatf("v%0d_latency", i), t, tbl[i].lat);
      chk($sformatf("v%0d_ack_error", i), ack_error, tbl[i].err);
      chk($sformatf("v%0d_rdata", i), rdata, tbl[i].rd);
      chk($sformatf("v%0d_stop_count", i), np, 1);
      if (!tbl[i].rw && !tbl[i].nodev)
        chk($sformatf("v%0d_mem", i), mem[tbl[i].addr], tbl[i].wd);
      if (tbl[i].rw && !tbl[i].nodev) begin
        chk($sformatf("v%0d_start_count", i), ns, 2);
        chk($sformatf("v%0d_restart_byte", i), dev_byte, 8'hA1);
      end
    end
    nodev = 0;
    ce_half = 0;
    repeat (4) @(posedge clk);
    #1;

    // start pulsed mid-write with different command fields
    run_txn(0, 13'h0ABC, 8'h11, 20, t, ns, np);
    chk("glitch_latency", t, 152);
    chk("glitch_mem", mem[13'h0ABC], 8'h11);
    chk("glitch_other_mem", mem[13'h1543], 8'h00);

    // reset 70 ticks into a read
    rw = 1; mem_address = 13'h1234; start = 1;
    accept();
    start = 0;
    for (int i = 0; i < 70; i++) accept();
    reset = 1;
    #1;
    chk("async_reset_lines", {scl, sda_out, busy, done}, 4'b1100);
    chk("async_reset_rdata", rdata, 8'h00);
    @(negedge clk) reset = 0;
    repeat (2) @(posedge clk);
    #1;
    run_txn(1, 13'h1234, 8'h00, -1, t, ns, np);
    chk("after_reset_latency", t, 192);
    chk("after_reset_rdata", rdata, 8'h5A);

    // start held high straight through the done tick
    rw = 0; mem_address = 13'h0200; wdata = 8'h77; start = 1;
    accept();
    wait_done(0, 13'h0200, 8'h77, -1, t);
    chk("held_latency", t, 152);
    accept();
    chk("start_in_done_ignored", {busy, done}, 2'b00);
    accept();
    chk("start_after_done_taken", busy, 1);
    start = 0;
    wait_done(0, 13'h0200, 8'h77, -1, t);
    chk("held_second_latency", t, 152);
    chk("held_mem", mem[13'h0200], 8'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
